// File: rtl/history_display.sv
// history_display
//   Keeps the four most recent values of the display counter and scans them
//   onto four active-low common-anode seven-segment digits.
//
//   Ports
//     ClockIn      : single clock, everything updates on its rising edge
//     Reset        : asynchronous, active-low reset
//     EnableDC     : one-cycle tick from the counter stage (increment cycle)
//     CounterValue : counter output, valid from the cycle after EnableDC
//     Freeze       : suppresses history capture; the scan keeps running
//     History      : [3:0] newest entry ... [15:12] oldest entry
//     Valid        : number of filled history entries, 0..4
//     DigitSel     : one-hot active-low anode enables, bit i = digit i
//     Segments     : active-low segments {g,f,e,d,c,b,a}
module history_display #(
  parameter int REFRESH_DIV = 4
) (
  input  logic        ClockIn,
  input  logic        Reset,
  input  logic        EnableDC,
  input  logic [3:0]  CounterValue,
  input  logic        Freeze,
  output logic [15:0] History,
  output logic [2:0]  Valid,
  output logic [3:0]  DigitSel,
  output logic [6:0]  Segments
);

  localparam int            CW        = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] SCAN_LOAD = CW'(REFRESH_DIV - 1);

  // The digit index is the only state machine: it walks 0..3 and wraps.
  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_e;

  logic          tick_q, tick_d;
  logic [15:0]   history_q, history_d;
  logic [2:0]    valid_q, valid_d;
  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  digit_e        idx_q, idx_d;
  logic [3:0]    digit_sel_q, digit_sel_d;
  logic [6:0]    segments_q, segments_d;

  logic [1:0]    idx_bits;
  logic [3:0]    digit_nib;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Capture path. The counter shows its new value one cycle after the tick,
  // so the tick is delayed by one cycle to line up with that value.
  always_comb begin
    tick_d    = EnableDC;
    history_d = history_q;
    valid_d   = valid_q;
    if (tick_q && !Freeze) begin
      history_d = {history_q[11:0], CounterValue};
      valid_d   = (valid_q == 3'd4) ? 3'd4 : valid_q + 3'd1;
    end
  end

  // Scan divider and digit index next-state.
  always_comb begin
    scan_cnt_d = scan_cnt_q - CW'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == '0) begin
      scan_cnt_d = SCAN_LOAD;
      case (idx_q)
        DIG0:    idx_d = DIG1;
        DIG1:    idx_d = DIG2;
        DIG2:    idx_d = DIG3;
        default: idx_d = DIG0;
      endcase
    end
  end

  // Display outputs are registered from the current index and history, so
  // they trail idx by one cycle; a capture and an index change that land on
  // the same edge therefore reach the pins together.
  always_comb begin
    idx_bits    = idx_q;
    digit_nib   = history_q[{idx_bits, 2'b00} +: 4];
    digit_sel_d = ~(4'b0001 << idx_bits);
    if ({1'b0, idx_bits} >= valid_q) begin
      segments_d = 7'b1111111;  // empty slot: anode still driven, segments dark
    end else begin
      segments_d = hex7(digit_nib);
    end
  end

  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      tick_q      <= 1'b0;
      history_q   <= '0;
      valid_q     <= '0;
      scan_cnt_q  <= SCAN_LOAD;
      idx_q       <= DIG0;
      digit_sel_q <= 4'b1111;
      segments_q  <= 7'b1111111;
    end else begin
      tick_q      <= tick_d;
      history_q   <= history_d;
      valid_q     <= valid_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      digit_sel_q <= digit_sel_d;
      segments_q  <= segments_d;
    end
  end

  assign History  = history_q;
  assign Valid    = valid_q;
  assign DigitSel = digit_sel_q;
  assign Segments = segments_q;

endmodule

// File: tb/tb_history_display.sv
// Testbench for history_display: directed stimulus, a behavioural model of
// the history and scan, a per-cycle compare process and literal checkpoints.
module tb_history_display;

  localparam int R = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic [3:0]  cv    = 4'h0;
  logic        frz   = 1'b0;
  logic [15:0] hist;
  logic [2:0]  valid;
  logic [3:0]  dsel;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  history_display #(.REFRESH_DIV(R)) dut (
    .ClockIn      (clk),
    .Reset        (rst_n),
    .EnableDC     (en),
    .CounterValue (cv),
    .Freeze       (frz),
    .History      (hist),
    .Valid        (valid),
    .DigitSel     (dsel),
    .Segments     (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the history as a list of captured values, how many
  // are held, and how many edges have passed since reset release. The display
  // shows the history as it was one cycle earlier, on the digit given by
  // the elapsed edge count divided by the refresh period.
  logic [15:0] m_hist, m_disp_hist;
  int          m_cnt, m_disp_cnt, m_edges;
  logic        m_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hist      <= '0;
      m_cnt       <= 0;
      m_disp_hist <= '0;
      m_disp_cnt  <= 0;
      m_edges     <= 0;
      m_tick      <= 1'b0;
    end else begin
      m_edges     <= m_edges + 1;
      m_tick      <= en;
      m_disp_hist <= m_hist;
      m_disp_cnt  <= m_cnt;
      if (m_tick && !frz) begin
        m_hist <= {m_hist[11:0], cv};
        m_cnt  <= (m_cnt < 4) ? m_cnt + 1 : 4;
      end
    end
  end

  always @(negedge clk) begin
    int         d;
    logic [3:0] esel;
    logic [6:0] eseg;
    if (m_edges == 0) begin
      esel = 4'b1111;
      eseg = 7'b1111111;
    end else begin
      d    = ((m_edges - 1) / R) % 4;
      esel = ~(4'b0001 << d);
      eseg = (d >= m_disp_cnt) ? 7'b1111111 : hex_tab[m_disp_hist[4*d +: 4]];
    end
    check("model_history", 32'(hist), 32'(m_hist));
    check("model_valid", 32'(valid), 32'(m_cnt));
    check("model_digitsel", 32'(dsel), 32'(esel));
    check("model_segments", 32'(seg), 32'(eseg));
  end

  // Inputs change 2 time units after each rising edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Counter increment: tick in this cycle, new value from the next cycle.
  task automatic tick(input logic [3:0] v);
    en = 1'b1;
    step();
    en = 1'b0;
    cv = v;
    step();
    $display("tick value=%h freeze=%0b history=%h valid=%0d", v, frz, hist, valid);
  endtask

  task automatic wait_sel(input logic [3:0] want, input string name);
    int k = 0;
    while (dsel !== want && k < 64) begin
      step();
      k++;
    end
    check(name, 32'(dsel), 32'(want));
  endtask

  initial begin
    int run;

    // Reset held with ticks applied.
    rst_n = 1'b0;
    step();
    en = 1'b1; cv = 4'h5;
    step();
    en = 1'b0; cv = 4'h6;
    step();
    check("rst_history", 32'(hist), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_digitsel", 32'(dsel), 32'hF);
    check("rst_segments", 32'(seg), 32'h7F);
    cv    = 4'h0;
    rst_n = 1'b1;
    step();
    check("first_digitsel", 32'(dsel), 32'b1110);

    // Capture alignment: counter 0 -> 1.
    tick(4'h1);
    check("cap_history", 32'(hist), 32'h0001);
    check("cap_valid", 32'(valid), 32'd1);
    wait_sel(4'b1101, "cap_wait_d1");
    check("cap_d1_blank", 32'(seg), 32'h7F);
    wait_sel(4'b1110, "cap_wait_d0");
    check("cap_d0_one", 32'(seg), 32'b1111001);

    // Saturation and shift: values 2..6 after the 1 above.
    for (int v = 2; v <= 6; v++) tick(4'(v));
    check("sat_history", 32'(hist), 32'h3456);
    check("sat_valid", 32'(valid), 32'd4);
    wait_sel(4'b0111, "sat_wait_d3");
    wait_sel(4'b1110, "sat_wait_d0");
    check("sat_d0_six", 32'(seg), 32'b0000010);
    run = 0;
    while (dsel === 4'b1110 && run < 20) begin
      run++;
      step();
    end
    check("sat_d0_cycles", 32'(run), 32'd4);
    check("sat_d1_sel", 32'(dsel), 32'b1101);
    check("sat_d1_five", 32'(seg), 32'b0010010);
    wait_sel(4'b1011, "sat_wait_d2");
    check("sat_d2_four", 32'(seg), 32'b0011001);
    wait_sel(4'b0111, "sat_wait_d3b");
    check("sat_d3_three", 32'(seg), 32'b0110000);

    // Freeze drops ticks; release and capture A.
    frz = 1'b1;
    tick(4'h7);
    tick(4'h8);
    tick(4'h9);
    check("frz_history", 32'(hist), 32'h3456);
    frz = 1'b0;
    tick(4'hA);
    check("unfrz_history", 32'(hist), 32'h456A);
    check("unfrz_valid", 32'(valid), 32'd4);

    // Back-to-back ticks from a fresh reset.
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    cv    = 4'h0;
    en    = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      step();
      cv = 4'(v);
    end
    en = 1'b0;
    step();
    $display("burst of 4 ticks history=%h valid=%0d", hist, valid);
    check("b2b_history", 32'(hist), 32'h1234);
    check("b2b_valid", 32'(valid), 32'd4);

    // Asynchronous reset while digit 2 is lit, between edges.
    wait_sel(4'b1011, "ar_wait_d2");
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_history", 32'(hist), 32'h0);
    check("ar_valid", 32'(valid), 32'h0);
    check("ar_digitsel", 32'(dsel), 32'hF);
    check("ar_segments", 32'(seg), 32'h7F);
    step(2);
    rst_n = 1'b1;
    step();
    check("ar_restart_d0", 32'(dsel), 32'b1110);
    check("ar_restart_blank", 32'(seg), 32'h7F);
    step(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/history_display.md
# history_display

Display stage fed by the rate-divided display counter: it consumes the counter's enable tick (`EnableDC`) and 4-bit `CounterValue`, and keeps the four most recent counter values in a shift history. It time-multiplexes that history onto four active-low common-anode seven-segment digits, with blanking for empty slots and a freeze control. It sits between the counter stage and the board's HEX pins.

## Interface

- `REFRESH_DIV`, default 4: ClockIn cycles each digit stays lit; legal range 2..2^16.
- `ClockIn` input 1: single clock; all state is updated on its rising edge.
- `Reset` input 1: asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `EnableDC` input 1: one-cycle tick, asserted in the cycle in which the counter increments.
- `CounterValue` input 4: counter output; it holds the new value from the cycle after the `EnableDC` edge.
- `Freeze` input 1: when high, history capture is suppressed; the scan continues.
- `History` output 16: `[3:0]` newest entry, `[15:12]` oldest.
- `Valid` output 3: number of filled entries, 0..4.
- `DigitSel` output 4: one-hot, active-low anode enable; bit i lights digit i.
- `Segments` output 7: active-low, `{g,f,e,d,c,b,a}`.

## Operation

- **Capture alignment**
  - `tick_d` is `EnableDC` registered by one cycle.
  - In a cycle with `tick_d`=1 and `Freeze`=0, the block captures the post-increment `CounterValue` as follows:
    - `History` <= `{History[11:0], CounterValue}`
    - `Valid` <= min(`Valid`+1, 4)
  - With `tick_d`=1 and `Freeze`=1, the tick is dropped. It is not queued.
  - `Freeze` is sampled in the same cycle as `tick_d`.
- **Saturation:** once `Valid`=4, further captures shift the oldest entry out and `Valid` stays 4.
- **Scan divider**
  - `scan_cnt` has width $clog2(`REFRESH_DIV`).
  - It loads `REFRESH_DIV`-1 and counts down to 0.
  - On 0 it reloads and advances `idx`.
- **Digit index:** `idx` is 2 bits and runs 0→1→2→3→0, wrapping freely.
- **Scan FSM:** there is no other FSM state. The scan runs unconditionally out of reset.
- **Digit mapping:** digit i displays `History[4i+3:4i]`. Digit 0 is the newest entry.
- **Blanking:** if i >= `Valid`, `Segments` = 7'b1111111 while digit i is selected. `DigitSel` still asserts for that digit.
- **Decode:** standard hex 0–F, active-low. Examples:
  - 0 → 7'b1000000
  - 1 → 7'b1111001
  - 8 → 7'b0000000
  - A → 7'b0001000
  - F → 7'b0001110
- **Reset (`Reset`=0, asynchronous)**
  - `History`=0, `Valid`=0, `tick_d`=0, `idx`=0, `scan_cnt`=`REFRESH_DIV`-1.
  - `DigitSel`=4'b1111 (all off), `Segments`=7'b1111111.
- **Reset release:** on deassertion, normal operation starts on the next rising edge.
- **Reset mid-operation:** an assertion at any point, including mid-digit or during a capture cycle, clears the history immediately.

## Timing

- **Capture latency:** an `EnableDC` high in cycle N → `History`/`Valid` update at the edge ending cycle N+1. The new value is visible in cycle N+2.
- **Back-to-back ticks:** `EnableDC` high on consecutive cycles captures every cycle. The block needs no gap between ticks.
- **Registered outputs:** `DigitSel` and `Segments` are registered from `idx` and `History`, so they lag `idx` by one cycle.
- **Post-reset scan:**
  - First active `DigitSel` (4'b1110) appears one cycle after the first edge following reset release.
  - Each digit then stays selected exactly `REFRESH_DIV` cycles.
  - A full scan takes 4×`REFRESH_DIV` cycles.
- **Exactly one digit lit:** exactly one `DigitSel` bit is low in every cycle after the first post-reset output update.
- **Update during display:** a capture landing while digit i is lit changes `Segments` one cycle later, within the same digit slot. The block does not stall the scan.
- **Simultaneous capture and wrap:** a capture coinciding with an `idx` wrap (3→0) applies both. Digit 0 shows the new value on its first displayed cycle.

## Test plan

- **Reset:** hold `Reset`=0 for 3 cycles, with ticks applied → `History`=0, `Valid`=0, `DigitSel`=4'b1111, `Segments`=7'b1111111 throughout.
- **Capture alignment:** with `REFRESH_DIV`=4, pulse `EnableDC` while the counter goes 0→1 → `History[3:0]`=1 and `Valid`=1 two cycles after the pulse. Digits 1–3 are blank; digit 0 shows 7'b1111001.
- **Saturation and shift:** apply 6 ticks with values 1..6 → `History`=16'h3456, `Valid`=4. The scan shows 6, 5, 4, 3 on digits 0..3, with each `DigitSel` low for exactly 4 cycles.
- **Freeze:**
  - Apply `Freeze`=1 over 3 ticks (values 7, 8, 9) → `History` stays 16'h3456.
  - Release `Freeze`, then one tick with value A → `History`=16'h456A.
- **Back-to-back ticks:** `EnableDC` high for 4 consecutive cycles with the counter at 0 → `History`=16'h1234 and `Valid`=4.
- **Asynchronous reset mid-scan:** assert `Reset`=0 while digit 2 is lit, between clock edges → all outputs clear immediately. After release the scan restarts at digit 0.
